// File: rtl/comb_eval_if.sv
// Request/response bundle for comb_eval_sched: requesters drive the master side,
// the scheduler implements the slave side.
interface comb_eval_if #(
  parameter int N_REQ = 4,
  parameter int N_IN  = 6,
  parameter int N_OUT = 5
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*N_IN-1:0] req_vec;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [N_OUT-1:0]      rsp_out;

  modport master (
    output req_valid, req_vec, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out
  );

  modport slave (
    input  req_valid, req_vec, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out
  );
endinterface

// File: rtl/comb_eval_sched.sv
// Round-robin time-sharing of one combinational netlist among N_REQ requesters.
// The exhaustive-sweep signature engine is built only when COMB_EVAL_SWEEP_EN is defined.
module comb_eval_sched #(
  parameter int N_REQ  = 4,
  parameter int N_IN   = 6,
  parameter int N_OUT  = 5,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  comb_eval_if.slave       bus,
  output logic [N_IN-1:0]  dut_x,
  input  logic [N_OUT-1:0] dut_f,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [15:0]      sweep_sig
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(SETTLE - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N_REQ - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE_W  = 3'd1,
    ST_RESP      = 3'd2
`ifdef COMB_EVAL_SWEEP_EN
    , ST_SW_SETTLE = 3'd3,
    ST_SW_END    = 3'd4
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_IN-1:0]  dut_x_q, dut_x_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [N_OUT-1:0] rsp_out_q, rsp_out_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             gnt_found_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic [IDW:0]     scan_s;
  logic [N_REQ-1:0] req_ready_s;
  logic             sweep_go_s;

`ifdef COMB_EVAL_SWEEP_EN
  localparam logic [N_IN:0] V_LAST = {1'b0, {N_IN{1'b1}}};

  logic [N_IN:0] v_q, v_d;
  logic [N_IN:0] v_next_s;
  logic [15:0]   sig_q, sig_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // One step of the CCITT-polynomial signature with the netlist outputs folded in.
  function automatic logic [15:0] sig_step(input logic [15:0] sig, input logic [N_OUT-1:0] f);
    logic [15:0] fb;
    fb = sig[15] ? 16'h1021 : 16'h0000;
    return ({sig[14:0], 1'b0} ^ fb) ^ 16'(f);
  endfunction

  assign sweep_go_s = sweep_start;
  assign v_next_s   = v_q + {{N_IN{1'b0}}, 1'b1};
`else
  logic unused_sweep_start_s;

  assign sweep_go_s           = 1'b0;
  assign unused_sweep_start_s = sweep_start;
`endif

  // Round-robin search for the first valid requester at or after rr_q.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = {IDW{1'b0}};
    scan_s      = {(IDW+1){1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      scan_s = {1'b0, rr_q} + (IDW+1)'(k);
      if (scan_s >= (IDW+1)'(N_REQ)) begin
        scan_s = scan_s - (IDW+1)'(N_REQ);
      end else begin
        scan_s = scan_s;
      end
      if (!gnt_found_s && bus.req_valid[scan_s[IDW-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = scan_s[IDW-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Accept is only offered from IDLE, and a same-cycle sweep request takes precedence.
  always_comb begin
    req_ready_s = {N_REQ{1'b0}};
    if (rst_n && (state_q == ST_IDLE) && !sweep_go_s && gnt_found_s) begin
      req_ready_s[gnt_idx_s] = 1'b1;
    end else begin
      req_ready_s = {N_REQ{1'b0}};
    end
  end

  // Next-state and datapath update for transactions and sweeps.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    dut_x_d     = dut_x_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_valid_d = rsp_valid_q;
`ifdef COMB_EVAL_SWEEP_EN
    v_d    = v_q;
    sig_d  = sig_q;
    busy_d = busy_q;
    done_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef COMB_EVAL_SWEEP_EN
        if (sweep_start) begin
          state_d = ST_SW_SETTLE;
          busy_d  = 1'b1;
          sig_d   = 16'hFFFF;
          v_d     = {(N_IN+1){1'b0}};
          dut_x_d = {N_IN{1'b0}};
          cnt_d   = CNT_INIT;
        end else
`endif
        if (gnt_found_s) begin
          dut_x_d  = bus.req_vec[int'(gnt_idx_s)*N_IN +: N_IN];
          rsp_id_d = gnt_idx_s;
          rr_d     = (gnt_idx_s == ID_LAST) ? {IDW{1'b0}} : gnt_idx_s + IDW'(1);
          cnt_d    = CNT_INIT;
          state_d  = ST_SETTLE_W;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE_W: begin
        if (cnt_q == {CW{1'b0}}) begin
          rsp_out_d   = dut_f;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
`ifdef COMB_EVAL_SWEEP_EN
      ST_SW_SETTLE: begin
        if (cnt_q == {CW{1'b0}}) begin
          sig_d = sig_step(sig_q, dut_f);
          if (v_q == V_LAST) begin
            done_d  = 1'b1;
            state_d = ST_SW_END;
          end else begin
            v_d     = v_next_s;
            dut_x_d = v_next_s[N_IN-1:0];
            cnt_d   = CNT_INIT;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SW_END: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction or sweep in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= {IDW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      dut_x_q     <= {N_IN{1'b0}};
      rsp_id_q    <= {IDW{1'b0}};
      rsp_out_q   <= {N_OUT{1'b0}};
      rsp_valid_q <= 1'b0;
`ifdef COMB_EVAL_SWEEP_EN
      v_q    <= {(N_IN+1){1'b0}};
      sig_q  <= 16'h0000;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      dut_x_q     <= dut_x_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef COMB_EVAL_SWEEP_EN
      v_q    <= v_d;
      sig_q  <= sig_d;
      busy_q <= busy_d;
      done_q <= done_d;
`endif
    end
  end

  assign dut_x         = dut_x_q;
  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
`ifdef COMB_EVAL_SWEEP_EN
  assign sweep_busy = busy_q;
  assign sweep_done = done_q;
  assign sweep_sig  = sig_q;
`else
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;
  assign sweep_sig  = 16'h0000;
`endif
endmodule

// File: tb/tb_comb_eval_sched.sv
// Bench for comb_eval_sched with a stub netlist f = x[4:0] ^ {5{x[5]}}: a transaction-level
// model checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_comb_eval_sched;
  localparam int N_REQ  = 4;
  localparam int N_IN   = 6;
  localparam int N_OUT  = 5;
  localparam int SETTLE = 2;

  logic        clk;
  logic        rst_n;
  logic [5:0]  dut_x;
  logic [4:0]  dut_f;
  logic        sweep_start;
  logic        sweep_busy;
  logic        sweep_done;
  logic [15:0] sweep_sig;
  logic        sw_go;

  int checks   = 0;
  int failures = 0;

  comb_eval_if #(.N_REQ(N_REQ), .N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  comb_eval_sched #(.N_REQ(N_REQ), .N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dut_x       (dut_x),
    .dut_f       (dut_f),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_sig   (sweep_sig)
  );

  assign dut_f = dut_x[4:0] ^ {5{dut_x[5]}};
`ifdef COMB_EVAL_SWEEP_EN
  assign sw_go = sweep_start;
`else
  assign sw_go = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] net_f(input logic [5:0] x);
    return x[4:0] ^ {5{x[5]}};
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] s, input logic [4:0] f);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {11'd0, f};
  endfunction

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Model state: mode 0 idle, 1 transaction, 2 sweep; m_t counts cycles since entry.
  int          m_mode = 0;
  int          m_t    = 0;
  int          m_rr   = 0;
  logic [5:0]  m_x    = 6'd0;
  logic [1:0]  m_id   = 2'd0;
  logic [4:0]  m_out  = 5'd0;
  logic        m_valid = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  logic [15:0] m_sig   = 16'h0000;
  logic [15:0] sig_tab [0:64];

  // Compare against the model, then advance it with the inputs the next rising edge will see.
  always @(negedge clk) begin
    logic [3:0] exp_rdy;
    int g;
    if (!rst_n) begin
      m_mode = 0; m_t = 0; m_rr = 0; m_x = 6'd0; m_id = 2'd0; m_out = 5'd0;
      m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_sig = 16'h0000;
    end
    exp_rdy = 4'b0000;
    if (rst_n && m_mode == 0 && !sw_go) begin
      g = pick(bus.req_valid, m_rr);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    chk("cyc_dut_x", dut_x, m_x);
    chk("cyc_rsp_valid", bus.rsp_valid, m_valid);
    chk("cyc_rsp_id", bus.rsp_id, m_id);
    chk("cyc_rsp_out", bus.rsp_out, m_out);
    chk("cyc_req_ready", bus.req_ready, exp_rdy);
    chk("cyc_sweep_busy", sweep_busy, m_busy);
    chk("cyc_sweep_done", sweep_done, m_done);
    chk("cyc_sweep_sig", sweep_sig, m_sig);
    if (rst_n) begin
      case (m_mode)
        0: begin
`ifdef COMB_EVAL_SWEEP_EN
          if (sweep_start) begin
            m_mode = 2; m_t = 0; m_busy = 1'b1; m_x = 6'd0; m_sig = 16'hFFFF;
            sig_tab[0] = 16'hFFFF;
            for (int k = 0; k < 64; k++) sig_tab[k+1] = crc_upd(sig_tab[k], net_f(6'(k)));
          end else
`endif
          begin
            g = pick(bus.req_valid, m_rr);
            if (g >= 0) begin
              m_x = bus.req_vec[g*6 +: 6]; m_id = 2'(g); m_rr = (g + 1) % 4;
              m_mode = 1; m_t = 0;
            end
          end
        end
        1: begin
          if (m_valid) begin
            if (bus.rsp_ready) begin m_valid = 1'b0; m_mode = 0; end
          end else begin
            m_t++;
            if (m_t == SETTLE) begin m_valid = 1'b1; m_out = net_f(m_x); end
          end
        end
        default: begin
          m_t++;
          if (m_t <= 64*SETTLE) begin
            m_x    = 6'((m_t/SETTLE > 63) ? 63 : m_t/SETTLE);
            m_sig  = sig_tab[m_t/SETTLE];
            m_done = (m_t == 64*SETTLE);
          end else begin
            m_busy = 1'b0; m_done = 1'b0; m_mode = 0;
          end
        end
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  ids [5];
    logic [4:0]  outs [5];
    int          at [5];
    logic [1:0]  exp_ids [5];
    logic [4:0]  exp_outs [5];
    int n, busy_n, done_n, guard, vn;
    logic [15:0] ref_sig;
    exp_ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_outs = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h01};

    rst_n = 1'b0; bus.req_valid = 4'h0; bus.req_vec = 24'h0; bus.rsp_ready = 1'b1; sweep_start = 1'b0;
    repeat (3) cyc();
    bus.req_valid = 4'hF;
    #1;
    chk("rst_req_ready", bus.req_ready, 4'h0);
    chk("rst_dut_x", dut_x, 6'h00);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_sweep_sig", sweep_sig, 16'h0000);
    bus.req_valid = 4'h0;
    cyc();
    rst_n = 1'b1;

    // Single request 0x2A from requester 0.
    bus.req_vec[5:0] = 6'h2A; bus.req_valid = 4'b0001;
    cyc();
    bus.req_valid = 4'b0000;
    chk("t1_wait0", bus.rsp_valid, 1'b0);
    cyc();
    chk("t1_wait1", bus.rsp_valid, 1'b0);
    cyc();
    chk("t1_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t1_rsp_id", bus.rsp_id, 2'd0);
    chk("t1_rsp_out", bus.rsp_out, 5'h15);
    cyc();
    chk("t1_handshake", bus.rsp_valid, 1'b0);
    cyc();
    chk("t1_dut_x_hold", dut_x, 6'h2A);

    // All four requesting from reset: grant order 0,1,2,3,0 at 4-cycle spacing.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.req_vec = {6'd4, 6'd3, 6'd2, 6'd1}; bus.req_valid = 4'hF;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (bus.rsp_valid) begin
        if (n < 5) begin ids[n] = bus.rsp_id; outs[n] = bus.rsp_out; at[n] = i; end
        n++;
      end
    end
    bus.req_valid = 4'h0;
    chk("t2_rsp_count", n, 5);
    for (int k = 0; k < 5 && k < n; k++) begin
      chk("t2_rsp_id", ids[k], exp_ids[k]);
      chk("t2_rsp_out", outs[k], exp_outs[k]);
      if (k > 0) chk("t2_spacing", at[k] - at[k-1], 4);
    end
    cyc();

    // Back-pressure: rsp_ready low for 5 cycles while every requester asks.
    bus.rsp_ready = 1'b0; bus.req_vec[11:6] = 6'h07; bus.req_valid = 4'b0010;
    cyc();
    bus.req_valid = 4'h0;
    cyc();
    cyc();
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", bus.rsp_valid, 1'b1);
      chk("t3_hold_id", bus.rsp_id, 2'd1);
      chk("t3_hold_out", bus.rsp_out, 5'h07);
      chk("t3_no_ready", bus.req_ready, 4'h0);
      cyc();
    end
    bus.req_valid = 4'h0; bus.rsp_ready = 1'b1;
    cyc();
    chk("t3_release", bus.rsp_valid, 1'b0);
    cyc();

`ifdef COMB_EVAL_SWEEP_EN
    // Sweep beats a simultaneous request from requester 2.
    bus.req_vec[17:12] = 6'h05; bus.req_valid = 4'b0100; sweep_start = 1'b1;
    #1;
    chk("t4_rdy_blocked", bus.req_ready, 4'h0);
    cyc();
    sweep_start = 1'b0;
    busy_n = 0; done_n = 0; guard = 0;
    while (sweep_busy && guard < 400) begin
      busy_n++;
      if (sweep_done) done_n++;
      cyc();
      guard++;
    end
    ref_sig = 16'hFFFF;
    for (int k = 0; k < 64; k++) ref_sig = crc_upd(ref_sig, net_f(6'(k)));
    chk("t4_busy_cycles", busy_n, 129);
    chk("t4_done_pulses", done_n, 1);
    chk("t4_sig", sweep_sig, ref_sig);
    chk("t4_rdy_after", bus.req_ready, 4'b0100);
    cyc();
    bus.req_valid = 4'h0;
    cyc();
    cyc();
    chk("t4_rsp_id", bus.rsp_id, 2'd2);
    chk("t4_rsp_out", bus.rsp_out, 5'h05);
    cyc();
    cyc();

    // Reset at sweep vector 30.
    sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    guard = 0;
    while (dut_x != 6'd30 && guard < 200) begin cyc(); guard++; end
    chk("t5_reach_v30", dut_x, 6'd30);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", sweep_busy, 1'b0);
    chk("t5_rst_sig", sweep_sig, 16'h0000);
    chk("t5_rst_dut_x", dut_x, 6'h00);
    cyc();
    rst_n = 1'b1;
    done_n = 0;
    repeat (140) begin cyc(); if (sweep_done) done_n++; end
    chk("t5_no_done", done_n, 0);
`else
    // Sweep not built: sweep_start ignored, request accepted straight away.
    bus.req_vec[5:0] = 6'h0F; bus.req_valid = 4'b0001; sweep_start = 1'b1;
    #1;
    chk("t6_rdy", bus.req_ready, 4'b0001);
    cyc();
    sweep_start = 1'b0; bus.req_valid = 4'h0;
    chk("t6_busy", sweep_busy, 1'b0);
    chk("t6_done", sweep_done, 1'b0);
    chk("t6_sig", sweep_sig, 16'h0000);
    cyc();
    cyc();
    chk("t6_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t6_rsp_out", bus.rsp_out, 5'h0F);
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
`endif

    // Reset during SETTLE_W, then a fresh request is served.
    bus.req_vec[5:0] = 6'h2A; bus.req_valid = 4'b0001;
    cyc();
    bus.req_valid = 4'h0;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", bus.rsp_valid, 1'b0);
    chk("t7_rst_dut_x", dut_x, 6'h00);
    chk("t7_rst_out", bus.rsp_out, 5'h00);
    cyc();
    rst_n = 1'b1;
    vn = 0;
    repeat (6) begin cyc(); if (bus.rsp_valid) vn++; end
    chk("t7_no_rsp", vn, 0);
    bus.req_vec[23:18] = 6'h21; bus.req_valid = 4'b1000;
    cyc();
    bus.req_valid = 4'h0;
    cyc();
    cyc();
    chk("t7_fresh_valid", bus.rsp_valid, 1'b1);
    chk("t7_fresh_id", bus.rsp_id, 2'd3);
    chk("t7_fresh_out", bus.rsp_out, 5'h1E);
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
